uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Oversampling UART receiver that feeds the Avalon UART slave's RX data and status registers.
- Runs entirely in the system clk domain and uses a one-cycle os_tick enable at OVERSAMPLE x baud, typically from the team's clock divider.
- Recovers frames of 5-8 data bits with optional parity and 1 stop bit.
- Holds each received byte until the register side acknowledges it, and flags parity, framing, overrun and break conditions.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8; rx_data is zero-extended above DATA_BITS.
- OVERSAMPLE, 16, os_tick pulses per bit period; must be even and >= 8.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- os_tick  input  1  one-clk sample strobe at OVERSAMPLE x baud
- rx  input  1  asynchronous serial line, idle high
- parity_en  input  1  1 = a parity bit follows the data bits
- parity_odd  input  1  1 = odd parity, 0 = even parity
- rx_ack  input  1  one-clk pulse; consumes the held byte
- err_clr  input  1  one-clk pulse; clears overrun_err and break_det
- rx_data  output  8  last received byte, LSB = first bit on the line
- rx_valid  output  1  byte held and not yet acknowledged
- parity_err  output  1  parity mismatch in the last committed frame
- frame_err  output  1  stop bit sampled 0 in the last committed frame
- overrun_err  output  1  sticky; a frame was committed while rx_valid = 1
- break_det  output  1  sticky; break frame received
- busy  output  1  state != IDLE

Behaviour:
- Reset: all outputs 0; synchronizer flops and the vote register preset to 1; state = IDLE.
- Synchronizer: rx passes through 2 flops to give rx_s.
- Vote register: 3-bit shift of rx_s, updated only on os_tick.
- Voted bit = majority of the 3 vote-register entries.
- cnt: log2(OVERSAMPLE)-bit counter, advanced only on os_tick.
- Bit index: 3-bit counter of data bits received.
- IDLE: on an os_tick with rx_s = 0, set cnt = 0 and go to START.
- START: on the os_tick where cnt = OVERSAMPLE/2-1:
  - voted bit 0: cnt = 0, go to DATA;
  - voted bit 1: go to IDLE as a glitch, nothing reported.
- Bit center is the os_tick where cnt = OVERSAMPLE-1; cnt wraps to 0 there.
- DATA:
  - At each bit center, shift the voted bit in, LSB first, and fold it into running parity.
  - After DATA_BITS bits, go to PARITY if parity_en = 1, else to STOP.
- PARITY: at the bit center, expected bit = XOR(data) XOR parity_odd; store the mismatch; go to STOP.
- STOP: at the bit center, commit the frame in the next clk:
  - rx_data = data; rx_valid = 1;
  - frame_err = ~stop; parity_err = stored mismatch, or 0 if parity_en = 0;
  - if rx_valid was already 1 and rx_ack is not asserted that cycle, set overrun_err; the new data overwrites the old;
  - if data = 0, stop = 0, and the parity bit (when enabled) = 0, set break_det.
- After STOP: go to WAIT_IDLE if stop = 0, else to IDLE.
- WAIT_IDLE: stay until rx_s = 1 on an os_tick, then go to IDLE. A held-low break therefore produces exactly one frame.
- Latency: rx_valid rises 1 clk after the stop-bit-center os_tick; about 9.5 bit times after the start edge for 8N1.
- rx_ack: clears rx_valid next clk; ignored when rx_valid = 0.
- rx_ack in the same cycle as a commit: the commit wins, rx_valid stays 1, no overrun.
- err_clr in the same cycle as a new overrun or break: the set wins.
- parity_err and frame_err change only at commit.
- os_tick low: all state is frozen.
- Asynchronous reset mid-frame: immediately return to reset values; the partial frame is discarded.
- Parameter or config changes mid-frame: undefined; software changes them only while busy = 0.

Test Plan:
- 8N1, OVERSAMPLE = 16, send 0xA5 -> rx_data = 0xA5, rx_valid = 1, all errors 0; rx_ack -> rx_valid = 0 next clk.
- parity_en = 1, parity_odd = 0, send 0x37 with parity bit 0 (correct is 1) -> rx_data = 0x37, parity_err = 1; then correct frame 0x37 -> parity_err = 0.
- rx low for 5 os_ticks then high -> state back to IDLE, busy = 0, rx_valid stays 0.
- Send 0x5A with stop bit 0 -> frame_err = 1, rx_data = 0x5A; line high -> IDLE; next good 0x11 -> frame_err = 0.
- Send 0x01 then 0x02 with no rx_ack -> rx_data = 0x02, overrun_err = 1; err_clr -> overrun_err = 0.
- Hold rx low for 20 bit times -> exactly one commit with rx_data = 0x00, frame_err = 1, break_det = 1; reset_n pulse mid-frame -> all outputs 0 and no commit.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop sync, 3-sample majority vote, 5..8 data bits, optional parity, 1 stop.
// Frames commit one clk after the stop-bit centre; the byte is held until rx_ack.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       os_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       break_det,
  output logic       busy
);

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sync;
  logic [2:0]    r_vote;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par_acc;
  logic          r_par_bit;
  logic          r_par_mis;
  logic          r_stop;
  logic          r_commit;
  logic          w_rx_s;
  logic          w_voted;
  logic          w_at_half;
  logic          w_at_center;
  logic          w_break;

  assign w_rx_s      = r_sync[1];
  assign w_voted     = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);
  assign w_at_half   = (r_cnt == HALF_M1);
  assign w_at_center = (r_cnt == FULL_M1);
  assign w_break     = (r_shift == 8'h00) && !r_stop && !(parity_en && r_par_bit);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_vote <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], rx};
      if (os_tick) r_vote <= {r_vote[1:0], w_rx_s};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (os_tick) begin
      case (r_state)
        S_IDLE:      if (!w_rx_s) w_state_nxt = S_START;
        S_START:     if (w_at_half) w_state_nxt = w_voted ? S_IDLE : S_DATA;
        S_DATA:      if (w_at_center && (r_bit_idx == LAST_BIT))
                       w_state_nxt = parity_en ? S_PARITY : S_STOP;
        S_PARITY:    if (w_at_center) w_state_nxt = S_STOP;
        S_STOP:      if (w_at_center) w_state_nxt = w_voted ? S_IDLE : S_WAIT_IDLE;
        S_WAIT_IDLE: if (w_rx_s) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Counter and bit sampling; everything here advances only on os_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_par_bit <= 1'b0;
      r_par_mis <= 1'b0;
      r_stop    <= 1'b1;
    end else if (os_tick) begin
      case (r_state)
        S_IDLE: if (!w_rx_s) r_cnt <= '0;
        S_START: begin
          if (w_at_half) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_par_bit <= 1'b0;
            r_par_mis <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_at_center) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_voted;
            r_par_acc          <= r_par_acc ^ w_voted;
            r_bit_idx          <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_at_center) begin
            r_cnt     <= '0;
            r_par_bit <= w_voted;
            r_par_mis <= w_voted ^ r_par_acc ^ parity_odd;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_at_center) begin
            r_cnt  <= '0;
            r_stop <= w_voted;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_commit <= 1'b0;
    else          r_commit <= os_tick && (r_state == S_STOP) && w_at_center;
  end

  // Commit has priority over rx_ack and err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      if (r_commit) begin
        rx_data    <= r_shift;
        rx_valid   <= 1'b1;
        frame_err  <= ~r_stop;
        parity_err <= parity_en & r_par_mis;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (r_commit && rx_valid && !rx_ack) overrun_err <= 1'b1;
      else if (err_clr)                    overrun_err <= 1'b0;
      if (r_commit && w_break) break_det <= 1'b1;
      else if (err_clr)        break_det <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frame table, hand-timed corner sequences, then random frames
// checked against a frame-level model of the receiver's register outputs.
module tb_uart_rx_os;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  logic       clk;
  logic       reset_n;
  logic       os_tick;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       break_det;
  logic       busy;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset_n(reset_n), .os_tick(os_tick), .rx(rx),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx_ack(rx_ack), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .break_det(break_det), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;
  int tph    = 0;

  typedef struct {
    logic [7:0] d;
    logic       pen, podd, pb, sb, ack, clr;
    logic [7:0] e_data;
    logic       e_perr, e_ferr, e_ovr, e_brk;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    os_tick = (tph == 0);
    tph     = (tph == TICK_DIV - 1) ? 0 : tph + 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align();
    while (tph != 0) step();
  endtask

  task automatic pulse_ack();
    step(); rx_ack = 1'b1;
    step(); rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
  endtask

  // Drives one 8-bit frame plus two idle bit times; optionally pulses rx_ack or err_clr
  // at clk offset inj_at; returns the offset at which rx_valid was first seen rising.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int inj_at, input bit inj_clr, output int vld_n);
    logic [13:0] bits;
    int          nb;
    logic        prev_v;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (parity_en) begin
      bits[nb] = pb;
      nb++;
    end
    bits[nb] = sb;
    nb++;
    vld_n  = -1;
    prev_v = rx_valid;
    align();
    for (int n = 0; n < (nb + 2) * BIT_CLKS; n++) begin
      step();
      if (vld_n < 0 && rx_valid && !prev_v) vld_n = n;
      prev_v  = rx_valid;
      rx      = bits[n / BIT_CLKS];
      rx_ack  = (n == inj_at) && !inj_clr;
      err_clr = (n == inj_at) && inj_clr;
    end
    rx_ack  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_d, input logic e_v, input logic e_pe,
                         input logic e_fe, input logic e_ov, input logic e_bk);
    chk({tag, ".rx_data"},     rx_data,     e_d);
    chk({tag, ".rx_valid"},    rx_valid,    e_v);
    chk({tag, ".parity_err"},  parity_err,  e_pe);
    chk({tag, ".frame_err"},   frame_err,   e_fe);
    chk({tag, ".overrun_err"}, overrun_err, e_ov);
    chk({tag, ".break_det"},   break_det,   e_bk);
  endtask

  // Frame-level reference state for the random phase.
  logic [7:0] m_data;
  logic       m_valid, m_perr, m_ferr, m_ovr, m_brk;

  initial begin
    int   k_commit;
    int   dummy;
    logic [7:0] d;
    logic pb, sb, want_ack, want_clr;

    reset_n = 1'b0; os_tick = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    rx_ack = 1'b0; err_clr = 1'b0;

    //            d     pen   podd  pb    sb    ack   clr   e_data e_perr e_ferr e_ovr e_brk
    tbl[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};

    steps(5);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.busy", busy, 1'b0);
    reset_n = 1'b1;
    steps(8);

    for (int i = 0; i < 11; i++) begin
      parity_en  = tbl[i].pen;
      parity_odd = tbl[i].podd;
      if (tbl[i].ack) begin
        pulse_ack();
        chk($sformatf("v%0d.ack_clears", i), rx_valid, 1'b0);
      end
      if (tbl[i].clr) begin
        pulse_clr();
        chk($sformatf("v%0d.clr_ovr", i), overrun_err, 1'b0);
        chk($sformatf("v%0d.clr_brk", i), break_det, 1'b0);
      end
      send_frame(tbl[i].d, tbl[i].pb, tbl[i].sb, -1, 1'b0, dummy);
      chk_all($sformatf("v%0d", i), tbl[i].e_data, 1'b1, tbl[i].e_perr, tbl[i].e_ferr,
              tbl[i].e_ovr, tbl[i].e_brk);
      chk($sformatf("v%0d.busy", i), busy, 1'b0);
    end

    // Short low pulse is rejected as a glitch.
    parity_en = 1'b0; parity_odd = 1'b0;
    pulse_ack();
    align();
    rx = 1'b0;
    steps(12);
    chk("glitch.busy_mid", busy, 1'b1);
    steps(8);
    rx = 1'b1;
    steps(2 * BIT_CLKS);
    chk("glitch.busy", busy, 1'b0);
    chk("glitch.rx_valid", rx_valid, 1'b0);

    // Measure commit offset; it should land about 9.5 bit times after the start edge.
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0, k_commit);
    chk("latency.window", (k_commit >= 9 * BIT_CLKS) && (k_commit <= 10 * BIT_CLKS), 1'b1);
    chk("latency.rx_data", rx_data, 8'h3C);

    // rx_ack landing on the commit cycle: commit wins, no overrun.
    send_frame(8'hC3, 1'b0, 1'b1, k_commit - 1, 1'b0, dummy);
    chk_all("ack_at_commit", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // err_clr landing on the overrun-setting cycle: set wins.
    send_frame(8'h69, 1'b0, 1'b1, k_commit - 1, 1'b1, dummy);
    chk_all("clr_at_overrun", 8'h69, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Held break: exactly one commit, so no overrun despite no ack afterwards.
    pulse_clr();
    pulse_ack();
    align();
    rx = 1'b0;
    steps(20 * BIT_CLKS);
    rx = 1'b1;
    steps(2 * BIT_CLKS);
    chk_all("break", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("break.busy", busy, 1'b0);

    // Asynchronous reset mid-frame.
    align();
    rx = 1'b0;
    steps(3 * BIT_CLKS);
    chk("rst_mid.busy_before", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.busy", busy, 1'b0);
    steps(3);
    rx = 1'b1;
    reset_n = 1'b1;
    steps(12 * BIT_CLKS);
    chk("rst_mid.no_commit", rx_valid, 1'b0);
    chk("rst_mid.busy_after", busy, 1'b0);

    m_data = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_brk = 1'b0;
    for (int f = 0; f < 30; f++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      d          = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      pb         = (^d) ^ parity_odd ^ ($urandom_range(0, 3) == 0);
      sb         = ($urandom_range(0, 3) != 0);
      want_ack   = 1'($urandom_range(0, 1));
      want_clr   = ($urandom_range(0, 3) == 0);
      if (want_ack) begin
        pulse_ack();
        m_valid = 1'b0;
      end
      if (want_clr) begin
        pulse_clr();
        m_ovr = 1'b0;
        m_brk = 1'b0;
      end
      send_frame(d, pb, sb, -1, 1'b0, dummy);
      m_ovr   = m_ovr | m_valid;
      m_valid = 1'b1;
      m_data  = d;
      m_ferr  = !sb;
      m_perr  = parity_en && (pb != ((^d) ^ parity_odd));
      m_brk   = m_brk | ((d == 8'h00) && !sb && !(parity_en && pb));
      chk_all($sformatf("rnd%0d", f), m_data, m_valid, m_perr, m_ferr, m_ovr, m_brk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
